// File: rtl/fg_cond_pkg.sv
// Shared types and defaults for the fast-gate signal conditioner.
// Holds the lock-state enum, counter width and default timing windows.
package fg_cond_pkg;

    localparam int CNT_W = 24;

    localparam int DEF_FILTER_CYCLES = 8;
    localparam int DEF_PERIOD_MIN    = 1_900_000;
    localparam int DEF_PERIOD_MAX    = 2_100_000;
    localparam int DEF_WIDTH_MIN     = 18_000;
    localparam int DEF_WIDTH_MAX     = 22_000;
    localparam int DEF_LOCK_COUNT    = 4;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } lock_state_e;

    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output follows
// the synchronized level only after it has disagreed for FILTER_CYCLES+1 samples.
module sync_glitch_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_signal,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    always_comb begin
        sync_d  = {sync_q[0], din};
        cnt_d   = '0;
        clean_d = clean_q;
        // Counting to FILTER_CYCLES (not FILTER_CYCLES-1) gives 2+FILTER_CYCLES total latency.
        if (sync_q[1] != clean_q) begin
            if (cnt_q == CW'(FILTER_CYCLES)) clean_d = sync_q[1];
            else                             cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign dout = clean_q;

endmodule

// File: rtl/fg_signal_conditioner.sv
// Fast-gate conditioner: cleans the opto level, measures period and high width,
// and runs a lock FSM that gates the fg_pulse strobe to the experiment FSM.
module fg_signal_conditioner
    import fg_cond_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int PERIOD_MIN    = DEF_PERIOD_MIN,
    parameter int PERIOD_MAX    = DEF_PERIOD_MAX,
    parameter int WIDTH_MIN     = DEF_WIDTH_MIN,
    parameter int WIDTH_MAX     = DEF_WIDTH_MAX,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             fg_opto,
    output logic             fg_clean,
    output logic             fg_pulse,
    output logic             fg_locked,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] width_cycles,
    output logic [7:0]       loss_count
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] W_MIN = CNT_W'(WIDTH_MIN);
    localparam logic [CNT_W-1:0] W_MAX = CNT_W'(WIDTH_MAX);

    logic              clean;
    logic              clean_prev_q;
    logic              rise, fall, timeout, per_good, wid_good;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  wid_cnt_q, wid_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [7:0]        loss_q, loss_d;
    logic              pulse_q, pulse_d;
    logic              locked_q, locked_d;
    lock_state_e       state_q, state_d;

    sync_glitch_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clock       (clock),
        .reset_signal(reset_signal),
        .din         (fg_opto),
        .dout        (clean)
    );

    always_comb begin
        rise     = clean & ~clean_prev_q;
        fall     = ~clean & clean_prev_q;
        per_good = in_range(per_cnt_q, P_MIN, P_MAX);
        wid_good = in_range(wid_cnt_q, W_MIN, W_MAX);
        // A rise in the same cycle as the overrun is still measured as a period.
        timeout  = (per_cnt_q > P_MAX) && !rise;
        good_inc = good_q + 1'b1;

        per_cnt_d = rise ? CNT_W'(1) : (per_cnt_q == CNT_SAT) ? per_cnt_q : per_cnt_q + 1'b1;
        wid_cnt_d = rise ? CNT_W'(1)
                  : (clean && wid_cnt_q != CNT_SAT) ? wid_cnt_q + 1'b1 : wid_cnt_q;

        period_d = period_q;
        if (rise && (state_q == ST_ACQUIRE || state_q == ST_LOCKED)) period_d = per_cnt_q;
        width_d = fall ? wid_cnt_q : width_q;

        state_d = state_q;
        good_d  = good_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (rise) begin
                    if (per_good) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_W'(LOCK_COUNT)) state_d = ST_LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
                if (fall && !wid_good) good_d = '0;
            end
            ST_LOCKED: begin
                if (rise) begin
                    if (per_good) pulse_d = 1'b1;
                    else          state_d = ST_LOST;
                end else if ((fall && !wid_good) || timeout) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // LOST is only ever held for one cycle, so state_d==LOST marks entry.
        loss_d   = (state_d == ST_LOST && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            clean_prev_q <= 1'b0;
            per_cnt_q    <= '0;
            wid_cnt_q    <= '0;
            period_q     <= '0;
            width_q      <= '0;
            good_q       <= '0;
            loss_q       <= '0;
            pulse_q      <= 1'b0;
            locked_q     <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            clean_prev_q <= clean;
            per_cnt_q    <= per_cnt_d;
            wid_cnt_q    <= wid_cnt_d;
            period_q     <= period_d;
            width_q      <= width_d;
            good_q       <= good_d;
            loss_q       <= loss_d;
            pulse_q      <= pulse_d;
            locked_q     <= locked_d;
            state_q      <= state_d;
        end
    end

    assign fg_clean      = clean;
    assign fg_pulse      = pulse_q;
    assign fg_locked     = locked_q;
    assign period_cycles = period_q;
    assign width_cycles  = width_q;
    assign loss_count    = loss_q;

endmodule

// File: tb/tb_fg_signal_conditioner.sv
// Bench for fg_signal_conditioner: directed and random pulse trains checked
// against an event-level model of periods, widths and lock status.
module tb_fg_signal_conditioner;
    localparam int FILT  = 8;
    localparam int P_MIN = 180;
    localparam int P_MAX = 220;
    localparam int W_MIN = 18;
    localparam int W_MAX = 22;
    localparam int LOCKN = 4;
    localparam int TMO   = P_MAX + 1;
    localparam int LAT   = FILT + 4;
    localparam int LEAD  = 20;
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

    logic        clock = 1'b0;
    logic        reset_signal = 1'b1;
    logic        fg_opto = 1'b0;
    logic        fg_clean, fg_pulse, fg_locked;
    logic [23:0] period_cycles, width_cycles;
    logic [7:0]  loss_count;

    int n_tests = 0;
    int n_fail  = 0;
    int np;
    int pp[40];
    int pw[40];

    fg_signal_conditioner #(
        .FILTER_CYCLES(FILT), .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX),
        .WIDTH_MIN(W_MIN), .WIDTH_MAX(W_MAX), .LOCK_COUNT(LOCKN)
    ) dut (
        .clock(clock), .reset_signal(reset_signal), .fg_opto(fg_opto),
        .fg_clean(fg_clean), .fg_pulse(fg_pulse), .fg_locked(fg_locked),
        .period_cycles(period_cycles), .width_cycles(width_cycles), .loss_count(loss_count)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset_signal = 1'b1;
        fg_opto = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_signal = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clock); #1;
        n_tests++; if (fg_clean !== 1'b0) begin n_fail++; $display("FAIL reset fg_clean got %b want 0", fg_clean); end
        n_tests++; if (fg_pulse !== 1'b0) begin n_fail++; $display("FAIL reset fg_pulse got %b want 0", fg_pulse); end
        n_tests++; if (fg_locked !== 1'b0) begin n_fail++; $display("FAIL reset fg_locked got %b want 0", fg_locked); end
        n_tests++; if (period_cycles !== 24'd0) begin n_fail++; $display("FAIL reset period got %0d want 0", period_cycles); end
        n_tests++; if (width_cycles !== 24'd0) begin n_fail++; $display("FAIL reset width got %0d want 0", width_cycles); end
        n_tests++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset loss got %0d want 0", loss_count); end
    endtask

    // 5-cycle glitch must vanish; a 9-cycle level must appear 10 edges after its first sample.
    task automatic test_glitch_filter();
        int highs;
        do_reset();
        highs = 0;
        for (int j = 0; j <= 70; j++) begin
            @(posedge clock); #1;
            if (j < 40 && fg_clean) highs++;
            if (j == 40) begin
                n_tests++; if (highs != 0) begin n_fail++; $display("FAIL glitch5 high cycles got %0d want 0", highs); end
            end
            if (j == 50) begin
                n_tests++; if (fg_clean !== 1'b0) begin n_fail++; $display("FAIL filter_early got %b want 0", fg_clean); end
            end
            if (j == 51) begin
                n_tests++; if (fg_clean !== 1'b1) begin n_fail++; $display("FAIL filter_rise got %b want 1", fg_clean); end
            end
            if (j == 59) begin
                n_tests++; if (fg_clean !== 1'b1) begin n_fail++; $display("FAIL filter_hold got %b want 1", fg_clean); end
            end
            if (j == 60) begin
                n_tests++; if (fg_clean !== 1'b0) begin n_fail++; $display("FAIL filter_fall got %b want 0", fg_clean); end
            end
            fg_opto = (j >= 5 && j < 10) || (j >= 40 && j < 49);
        end
    endtask

    // Plays pulses pp/pw (pp[k] = rise-to-rise distance before pulse k) and checks
    // each rise, fall and the trailing timeout against an event-level model.
    task automatic run_scen(input string tag);
        int s[40];
        int e_pulse[40], e_per[40], e_lk_r[40], e_loss_r[40], e_lk_f[40], e_loss_f[40];
        int st, good, loss, per_reg, exp_tot, obs_tot, lk_pre, last_s, end_j, kr, kf;
        logic ok;
        do_reset();
        s[0] = LEAD;
        for (int k = 1; k < np; k++) s[k] = s[k-1] + pp[k];
        st = M_IDLE; good = 0; loss = 0; per_reg = 0; exp_tot = 0;
        for (int k = 0; k < np; k++) begin
            if (k > 0 && st != M_IDLE && pp[k] > TMO) begin
                if (st == M_LOCK) loss = (loss < 255) ? loss + 1 : 255;
                st = M_IDLE;
            end
            e_pulse[k] = 0;
            if (st == M_IDLE) begin
                st = M_ACQ; good = 0;
            end else begin
                per_reg = pp[k];
                ok = (pp[k] >= P_MIN) && (pp[k] <= P_MAX);
                if (st == M_ACQ) begin
                    good = ok ? good + 1 : 0;
                    if (good == LOCKN) st = M_LOCK;
                end else if (ok) begin
                    e_pulse[k] = 1; exp_tot++;
                end else begin
                    loss = (loss < 255) ? loss + 1 : 255; st = M_IDLE;
                end
            end
            e_per[k] = per_reg; e_lk_r[k] = (st == M_LOCK); e_loss_r[k] = loss;
            ok = (pw[k] >= W_MIN) && (pw[k] <= W_MAX);
            if (!ok && st == M_ACQ) good = 0;
            if (!ok && st == M_LOCK) begin loss = (loss < 255) ? loss + 1 : 255; st = M_IDLE; end
            e_lk_f[k] = (st == M_LOCK); e_loss_f[k] = loss;
        end
        lk_pre = (st == M_LOCK);
        if (st == M_LOCK) loss = (loss < 255) ? loss + 1 : 255;

        last_s = s[np-1];
        end_j = last_s + TMO + LAT + 5;
        obs_tot = 0; kr = 0; kf = 0;
        for (int j = 0; j <= end_j; j++) begin
            @(posedge clock); #1;
            if (fg_pulse) obs_tot++;
            if (kr < np && j == s[kr] + LAT) begin
                n_tests++; if (fg_pulse !== e_pulse[kr][0]) begin n_fail++; $display("FAIL %s rise%0d pulse got %b want %0d", tag, kr, fg_pulse, e_pulse[kr]); end
                n_tests++; if (period_cycles !== 24'(e_per[kr])) begin n_fail++; $display("FAIL %s rise%0d period got %0d want %0d", tag, kr, period_cycles, e_per[kr]); end
                n_tests++; if (fg_locked !== e_lk_r[kr][0]) begin n_fail++; $display("FAIL %s rise%0d locked got %b want %0d", tag, kr, fg_locked, e_lk_r[kr]); end
                n_tests++; if (loss_count !== 8'(e_loss_r[kr])) begin n_fail++; $display("FAIL %s rise%0d loss got %0d want %0d", tag, kr, loss_count, e_loss_r[kr]); end
                kr++;
            end
            if (kf < np && j == s[kf] + pw[kf] + LAT) begin
                n_tests++; if (width_cycles !== 24'(pw[kf])) begin n_fail++; $display("FAIL %s fall%0d width got %0d want %0d", tag, kf, width_cycles, pw[kf]); end
                n_tests++; if (fg_locked !== e_lk_f[kf][0]) begin n_fail++; $display("FAIL %s fall%0d locked got %b want %0d", tag, kf, fg_locked, e_lk_f[kf]); end
                n_tests++; if (loss_count !== 8'(e_loss_f[kf])) begin n_fail++; $display("FAIL %s fall%0d loss got %0d want %0d", tag, kf, loss_count, e_loss_f[kf]); end
                kf++;
            end
            if (j == last_s + TMO + LAT - 1) begin
                n_tests++; if (fg_locked !== lk_pre[0]) begin n_fail++; $display("FAIL %s pre_timeout locked got %b want %0d", tag, fg_locked, lk_pre); end
            end
            if (j == last_s + TMO + LAT) begin
                n_tests++; if (fg_locked !== 1'b0) begin n_fail++; $display("FAIL %s timeout locked got %b want 0", tag, fg_locked); end
                n_tests++; if (loss_count !== 8'(loss)) begin n_fail++; $display("FAIL %s timeout loss got %0d want %0d", tag, loss_count, loss); end
            end
            fg_opto = 1'b0;
            for (int k = 0; k < np; k++)
                if (j >= s[k] && j < s[k] + pw[k]) fg_opto = 1'b1;
        end
        n_tests++; if (obs_tot != exp_tot) begin n_fail++; $display("FAIL %s pulse_total got %0d want %0d", tag, obs_tot, exp_tot); end
    endtask

    task automatic fill(input int n, input int per, input int wid);
        np = n;
        for (int k = 0; k < n; k++) begin pp[k] = per; pw[k] = wid; end
    endtask

    task automatic test_lock();
        fill(6, 200, 20);
        run_scen("lock");
    endtask

    task automatic test_bad_period();
        fill(8, 200, 20);
        pp[6] = 230;
        run_scen("bad_period");
        fill(8, 200, 20);
        pp[6] = 221;
        run_scen("period_221");
        fill(8, 200, 20);
        pp[6] = 179;
        run_scen("period_179");
    endtask

    task automatic test_timeout();
        fill(6, 200, 20);
        pp[2] = 180; pp[3] = 220;
        run_scen("timeout");
    endtask

    task automatic test_width_clear();
        fill(10, 200, 20);
        pw[3] = 25;
        run_scen("width_clear");
    endtask

    task automatic test_reset_on_rise();
        do_reset();
        for (int j = 0; j <= LEAD + 1600 + LAT + 1; j++) begin
            @(posedge clock); #1;
            if (j == LEAD + 1000 + LAT) begin
                n_tests++; if (fg_pulse !== 1'b1) begin n_fail++; $display("FAIL rst_rise pre_pulse got %b want 1", fg_pulse); end
            end
            if (j == LEAD + 1200 + LAT - 1) begin
                n_tests++; if (fg_locked !== 1'b1) begin n_fail++; $display("FAIL rst_rise pre_locked got %b want 1", fg_locked); end
                reset_signal = 1'b1;
            end
            if (j == LEAD + 1200 + LAT) begin
                n_tests++; if (fg_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_rise pulse got %b want 0", fg_pulse); end
                n_tests++; if (fg_locked !== 1'b0) begin n_fail++; $display("FAIL rst_rise locked got %b want 0", fg_locked); end
                n_tests++; if (fg_clean !== 1'b0) begin n_fail++; $display("FAIL rst_rise clean got %b want 0", fg_clean); end
                n_tests++; if (period_cycles !== 24'd0) begin n_fail++; $display("FAIL rst_rise period got %0d want 0", period_cycles); end
                n_tests++; if (width_cycles !== 24'd0) begin n_fail++; $display("FAIL rst_rise width got %0d want 0", width_cycles); end
                n_tests++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL rst_rise loss got %0d want 0", loss_count); end
            end
            if (j == LEAD + 1200 + LAT + 1) begin
                n_tests++; if (fg_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_rise late_pulse got %b want 0", fg_pulse); end
                reset_signal = 1'b0;
            end
            if (j == LEAD + 1400 + LAT) begin
                n_tests++; if (period_cycles !== 24'd0) begin n_fail++; $display("FAIL post_rst first_rise period got %0d want 0", period_cycles); end
                n_tests++; if (fg_locked !== 1'b0) begin n_fail++; $display("FAIL post_rst first_rise locked got %b want 0", fg_locked); end
            end
            if (j == LEAD + 1600 + LAT) begin
                n_tests++; if (period_cycles !== 24'd200) begin n_fail++; $display("FAIL post_rst second_rise period got %0d want 200", period_cycles); end
                n_tests++; if (fg_pulse !== 1'b0) begin n_fail++; $display("FAIL post_rst second_rise pulse got %b want 0", fg_pulse); end
            end
            fg_opto = (j >= LEAD) && (((j - LEAD) % 200) < 20);
        end
        fg_opto = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int sc = 0; sc < 3; sc++) begin
            np = 20;
            for (int k = 0; k < np; k++) begin
                r = $urandom_range(0, 11);
                if (r == 0)      pp[k] = $urandom_range(170, 179);
                else if (r == 1) pp[k] = ($urandom_range(0, 1) != 0) ? P_MIN : P_MAX;
                else if (r == 2) pp[k] = $urandom_range(221, 226);
                else             pp[k] = $urandom_range(185, 215);
                r = $urandom_range(0, 11);
                if (r == 0)      pw[k] = ($urandom_range(0, 1) != 0) ? 15 : 17;
                else if (r == 1) pw[k] = ($urandom_range(0, 1) != 0) ? 23 : 25;
                else if (r == 2) pw[k] = ($urandom_range(0, 1) != 0) ? W_MIN : W_MAX;
                else             pw[k] = $urandom_range(19, 21);
            end
            run_scen("random");
        end
    endtask

    initial begin
        test_reset();
        test_glitch_filter();
        test_lock();
        test_bad_period();
        test_timeout();
        test_width_clear();
        test_reset_on_rise();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
